knn_result_reader: RTL and testbench

- Read-side companion of the K-entry insertion sorter in the kNN datapath.
- On a start pulse it captures the sorter's K parallel ascending outputs in one cycle, then streams them out one entry per valid/ready handshake, smallest first.
- The sorter holds all-ones in a slot that has never been written. The reader treats all-ones as "empty" and stops at the first empty slot.
- Sits between the sorter and the software-visible result registers / vote logic.

---
 rtl/knn_result_reader.sv | 139 +++++++++++++
 tb/tb_knn_result_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_result_reader.sv
// knn_result_reader: snapshots the K-entry ascending list from the insertion
// sorter on a start pulse, then streams the non-empty entries (smallest
// first) over a valid/ready interface. All-ones marks an empty slot.
`timescale 1ns/1ps
module knn_result_reader #(
  parameter int W  = 32,
  parameter int K  = 4,
  parameter int IW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K*W-1:0]    data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [IW:0]       count
);

  localparam logic [W-1:0] EMPTY = '1;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    snap_reg [K];
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW:0]     count_reg;
  logic [IW:0]     lead_cnt;
  logic            seen_empty;
  logic            snap_load;
  logic [K-1:0]    in_empty;   // incoming entry equals the empty marker
  logic [K-1:0]    last_vec;   // snapshot entry is the final non-empty one
  logic            send_st;

  // Per-entry empty detection on the input and last-entry flags on the snapshot.
  // The top slot is always last since the pointer never goes past it.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_entry
      assign in_empty[gi] = (data_in[gi*W +: W] == EMPTY);
      if (gi == K-1) begin : g_top
        assign last_vec[gi] = 1'b1;
      end else begin : g_mid
        assign last_vec[gi] = (snap_reg[gi+1] == EMPTY);
      end
    end
  endgenerate

  // Count leading non-empty entries; the list is ascending so empties sit at the tail.
  always_comb begin
    lead_cnt   = '0;
    seen_empty = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (in_empty[i]) begin
        seen_empty = 1'b1;
      end else if (!seen_empty) begin
        lead_cnt = lead_cnt + {{IW{1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    snap_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          snap_load  = 1'b1;
          ptr_next   = '0;
          state_next = in_empty[0] ? FIN : SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_vec[ptr_reg]) begin
            state_next = FIN;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (snap_load) begin
        count_reg <= lead_cnt;
      end
    end
  end

  // Snapshot register; resets to all-empty and only loads on an accepted start.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (rst) begin
        snap_reg[i] <= EMPTY;
      end else if (snap_load) begin
        snap_reg[i] <= data_in[i*W +: W];
      end
    end
  end

  // Outputs decode directly from registered state; data fields read zero outside SEND.
  always_comb begin
    send_st   = (state_reg == SEND);
    out_valid = send_st;
    busy      = send_st;
    done      = (state_reg == FIN);
    count     = count_reg;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (send_st) begin
      out_data = snap_reg[ptr_reg];
      out_idx  = ptr_reg;
      out_last = last_vec[ptr_reg];
    end
  end

endmodule

// File: tb/tb_knn_result_reader.sv
// Testbench for knn_result_reader: table-driven lists plus hand-written
// sequences for ignored starts and mid-stream reset. Expected beats are
// queued at start and compared as the DUT hands them over.
`timescale 1ns/1ps
module tb_knn_result_reader;

  localparam int W  = 32;
  localparam int K  = 4;
  localparam int IW = 2;
  localparam logic [W-1:0] E = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [K*W-1:0]   data_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [IW:0]      count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    logic [K*W-1:0] d;
    int             cnt;
    int             mode;   // 0: ready held high, 1: ready pattern 1,0,0,1
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[6];

  int    done_cnt  = 0;
  time   done_time = 0;
  logic  prev_valid = 1'b0;
  logic  prev_ready = 1'b0;
  beat_t prev_beat;

  knn_result_reader #(.W(W), .K(K), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
    chk("rst_count",     count,     0);
  endtask

  task automatic push_beats(input logic [K*W-1:0] d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back('{data: d[i*W +: W], idx: IW'(i), last: (i == cnt-1)});
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      chk("busy_vs_valid", busy, out_valid);
      if (done) begin
        done_cnt++;
        done_time = $time;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data",  out_data,  prev_beat.data);
        chk("hold_idx",   out_idx,   prev_beat.idx);
        chk("hold_last",  out_last,  prev_beat.last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {out_idx, out_data}, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_idx",  out_idx,  b.idx);
          chk("beat_last", out_last, b.last);
          $display("beat idx=%0d data=0x%0h last=%0b", out_idx, out_data, out_last);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_beat  = '{data: out_data, idx: out_idx, last: out_last};
    end
  end

  task automatic run_vec(input int n, input logic [K*W-1:0] d, input int cnt, input int mode);
    int  d0;
    time t0;
    d0 = done_cnt;
    push_beats(d, cnt);
    data_in   = d;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
    for (int c = 0; c < 60 && done_cnt == d0; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      @(posedge clk);
      #1;
    end
    chk("done_seen", (done_cnt != d0), 1);
    if (mode == 0) chk("done_time", done_time - t0, cnt*10 + 5);
    @(posedge clk);
    #1;
    chk("done_pulses",   done_cnt - d0, 1);
    chk("count",         count, cnt);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    $display("vector %0d: count=%0d done_pulses=%0d", n, count, done_cnt - d0);
  endtask

  initial begin
    int  d0;
    logic [K*W-1:0] list_a;
    logic [K*W-1:0] list_b;

    vecs[0] = '{d: {32'd40, 32'd30, 32'd20, 32'd10},  cnt: 4, mode: 0};
    vecs[1] = '{d: {E, E, 32'd9, 32'd5},              cnt: 2, mode: 0};
    vecs[2] = '{d: {E, E, E, E},                      cnt: 0, mode: 0};
    vecs[3] = '{d: {32'd40, 32'd30, 32'd20, 32'd10},  cnt: 4, mode: 1};
    vecs[4] = '{d: {E, 32'd300, 32'd200, 32'd100},    cnt: 3, mode: 1};
    vecs[5] = '{d: {32'hFFFF_FFFE, 32'd7, 32'd7, 32'd0}, cnt: 4, mode: 0};
    list_a = {32'd40, 32'd30, 32'd20, 32'd10};
    list_b = {E, E, E, 32'd77};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven lists.
    for (int n = 0; n < 6; n++) begin
      run_vec(n, vecs[n].d, vecs[n].cnt, vecs[n].mode);
    end

    // Start while busy with different data: must not disturb the stream.
    d0 = done_cnt;
    push_beats(list_a, 4);
    data_in = list_a; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 60 && done_cnt == d0; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      start     = (c == 2);
      if (c == 2) data_in = list_b;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_start_done_seen", (done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_pulses", done_cnt - d0, 1);
    chk("busy_start_count",  count, 4);
    chk("busy_start_queue",  exp_q.size(), 0);
    exp_q.delete();
    $display("ignored start while busy: count=%0d done_pulses=%0d", count, done_cnt - d0);

    // Empty list, then start held into the done cycle: must be ignored.
    d0 = done_cnt;
    data_in = {E, E, E, E}; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 data_in = list_a;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("done_cycle_start_pulses", done_cnt - d0, 1);
    chk("done_cycle_start_count",  count, 0);
    chk("done_cycle_start_busy",   busy, 0);
    $display("ignored start in done cycle: count=%0d done_pulses=%0d", count, done_cnt - d0);

    // Reset after beat idx 1: abort with no done, then a fresh stream from idx 0.
    d0 = done_cnt;
    push_beats(list_a, 4);
    data_in = list_a; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 out_ready = 1'b0; rst = 1'b1;
    chk("abort_remaining", exp_q.size(), 2);
    @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    $display("mid-stream reset: done_pulses=%0d", done_cnt - d0);
    run_vec(6, {32'd4, 32'd3, 32'd2, 32'd1}, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
